// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_pkg
//  Brief    : Shared constants and helpers for the board I/O conditioning
//             stages that feed the processor's I/O ports.
//  Revision : 1.0  initial release
// ============================================================================
package io_pkg;

  // Width of every processor-facing I/O word
  localparam int IO_WORD_W = 32;

  // Board defaults: 18 slide switches, 50 MHz system clock
  localparam int SW_COUNT = 18;
  localparam int CLK_HZ   = 50_000_000;

  // Converts a settle time in milliseconds into a count of clock cycles
  function automatic int debounce_cycles(input int ms, input int clk_hz);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage : io_pkg
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce_bit
//  Brief    : One switch channel: metastability synchroniser, persistence
//             counter, accepted (stable) level and one-cycle edge pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  // A one-cycle debounce still needs a 1-bit counter; it simply stays at 0
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   stable;
  logic [CNT_W-1:0]       cnt;
  logic                   differ;
  logic                   expire;

  // Pure shift chain: nothing between stages so each flop gets a full cycle to resolve
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], raw_i};
  end

  assign s      = sync[SYNC_STAGES-1];
  assign differ = s ^ stable;
  // The change is accepted on the edge where the counter already shows DEBOUNCE_CYCLES-1
  assign expire = differ && (cnt == CNT_LAST);

  // Count consecutive disagreeing cycles; any agreement or an acceptance restarts from 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                cnt <= '0;
    else if (!differ || expire) cnt <= '0;
    else                        cnt <= cnt + CNT_ONE;
  end

  // Accepted level and the matching single-cycle edge pulse, updated together
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      if (expire) stable <= s;
      rise_o <= expire &  s;
      fall_o <= expire & ~s;
    end
  end

  assign stable_o = stable;

endmodule : sw_debounce_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Brief    : Synchronises and debounces the board slide switches, presenting
//             a zero-extended 32-bit switch word plus per-switch edge pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce
  import io_pkg::*;
#(
  parameter int NUM_SW          = SW_COUNT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = debounce_cycles(10, CLK_HZ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SW-1:0]    sw_raw_i,
  output logic [IO_WORD_W-1:0] io_sw_o,
  output logic [NUM_SW-1:0]    sw_rise_o,
  output logic [NUM_SW-1:0]    sw_fall_o
);

  // Reject illegal configurations while elaborating
  if (NUM_SW < 1 || NUM_SW > IO_WORD_W) begin : g_bad_num_sw
    $error("sw_debounce: NUM_SW must be within 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sw_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sw_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [NUM_SW-1:0] stable;

  // Every switch is an independent channel
  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .raw_i    (sw_raw_i[i]),
      .stable_o (stable[i]),
      .rise_o   (sw_rise_o[i]),
      .fall_o   (sw_fall_o[i])
    );
  end

  // Unused upper bits of the core word read as 0
  if (NUM_SW < IO_WORD_W) begin : g_pad
    assign io_sw_o = {{(IO_WORD_W-NUM_SW){1'b0}}, stable};
  end else begin : g_full
    assign io_sw_o = stable;
  end

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_debounce
//  Brief    : Directed self-checking bench for sw_debounce: a 4-switch,
//             4-cycle instance and a 32-switch, 1-cycle instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

  logic        clk;
  logic        rst_n;
  logic [3:0]  raw;
  logic [31:0] io;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic [31:0] raw_w;
  logic [31:0] io_w;
  logic [31:0] rise_w;
  logic [31:0] fall_w;

  int n_vec  = 0;
  int n_miss = 0;

  sw_debounce #(.NUM_SW(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sw_raw_i  (raw),
    .io_sw_o   (io),
    .sw_rise_o (rise),
    .sw_fall_o (fall)
  );

  sw_debounce #(.NUM_SW(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_wide (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sw_raw_i  (raw_w),
    .io_sw_o   (io_w),
    .sw_rise_o (rise_w),
    .sw_fall_o (fall_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge on the narrow instance, then check word and pulses
  task automatic step(input string tag, input logic [31:0] io_e,
                      input logic [3:0] r_e, input logic [3:0] f_e);
    tick();
    chk({tag, ".io"},   io,         io_e);
    chk({tag, ".rise"}, {28'd0, rise}, {28'd0, r_e});
    chk({tag, ".fall"}, {28'd0, fall}, {28'd0, f_e});
  endtask

  // Expect the word to move from old_io to new_io exactly lat edges from now
  task automatic expect_change(input string tag, input logic [31:0] old_io,
                               input logic [31:0] new_io, input int lat,
                               input logic [3:0] r_e, input logic [3:0] f_e);
    for (int e = 1; e <= lat + 1; e++) begin
      if (e < lat)       step($sformatf("%s.e%0d", tag, e), old_io, 4'h0, 4'h0);
      else if (e == lat) step($sformatf("%s.e%0d", tag, e), new_io, r_e, f_e);
      else               step($sformatf("%s.e%0d", tag, e), new_io, 4'h0, 4'h0);
    end
  endtask

  // Reset with raw held at v, then release just after an edge
  task automatic do_reset(input logic [3:0] v);
    rst_n = 1'b0;
    raw   = v;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    raw   = 4'hF;
    raw_w = 32'h0;

    // Reset holds everything at zero even with all switches up
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst.io",   io, 32'h0);
      chk("rst.rise", {28'd0, rise}, 32'h0);
      chk("rst.fall", {28'd0, fall}, 32'h0);
    end
    chk("rst.wide_io", io_w, 32'h0);
    rst_n = 1'b1;
    expect_change("rel_held", 32'h0, 32'hF, 6, 4'hF, 4'h0);

    // Clean single-bit change and its return
    do_reset(4'h0);
    step("idle", 32'h0, 4'h0, 4'h0);
    raw = 4'b0010;
    expect_change("clean_up", 32'h0, 32'h2, 6, 4'b0010, 4'h0);
    raw = 4'b0000;
    expect_change("clean_dn", 32'h2, 32'h0, 6, 4'h0, 4'b0010);

    // Three-cycle glitch never reaches the word
    raw = 4'b0001;
    tick(); tick(); tick();
    chk("glitch.io_mid", io, 32'h0);
    raw = 4'b0000;
    for (int k = 0; k < 8; k++) step($sformatf("glitch.e%0d", k), 32'h0, 4'h0, 4'h0);

    // Glitch then a held level: acceptance counts from the second rise
    raw = 4'b0001;
    tick(); tick(); tick();
    raw = 4'b0000;
    tick();
    raw = 4'b0001;
    expect_change("reglitch", 32'h0, 32'h1, 6, 4'b0001, 4'h0);
    raw = 4'b0000;
    expect_change("reglitch_dn", 32'h1, 32'h0, 6, 4'h0, 4'b0001);

    // Two bits changing together update together
    raw = 4'b1100;
    expect_change("simul_up", 32'h0, 32'hC, 6, 4'b1100, 4'h0);
    raw = 4'b0000;
    expect_change("simul_dn", 32'hC, 32'h0, 6, 4'h0, 4'b1100);

    // Bit 3 two cycles behind bit 2 lands two edges later
    raw = 4'b0100;
    step("stag.e1", 32'h0, 4'h0, 4'h0);
    step("stag.e2", 32'h0, 4'h0, 4'h0);
    raw = 4'b1100;
    step("stag.e3", 32'h0, 4'h0, 4'h0);
    step("stag.e4", 32'h0, 4'h0, 4'h0);
    step("stag.e5", 32'h0, 4'h0, 4'h0);
    step("stag.e6", 32'h4, 4'b0100, 4'h0);
    step("stag.e7", 32'h4, 4'h0, 4'h0);
    step("stag.e8", 32'hC, 4'b1000, 4'h0);
    step("stag.e9", 32'hC, 4'h0, 4'h0);

    // Reset mid-count clears the word without waiting for a clock edge
    raw = 4'b1101;
    tick(); tick(); tick();
    chk("midrst.pre", io, 32'hC);
    rst_n = 1'b0;
    #1;
    chk("midrst.async_io", io, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_change("midrst.rel", 32'h0, 32'hD, 6, 4'b1101, 4'h0);

    // Wide, single-cycle instance: three-edge latency and full 32-bit word
    raw_w = 32'hA5A5_0001;
    tick(); chk("wide.e1", io_w, 32'h0);
    tick(); chk("wide.e2", io_w, 32'h0);
    tick();
    chk("wide.e3",      io_w,   32'hA5A5_0001);
    chk("wide.e3_rise", rise_w, 32'hA5A5_0001);
    chk("wide.e3_fall", fall_w, 32'h0);
    raw_w = 32'h8000_0000;
    tick(); chk("wide.e4_rise", rise_w, 32'h0);
    tick(); chk("wide.f2", io_w, 32'hA5A5_0001);
    tick();
    chk("wide.f3",      io_w,   32'h8000_0000);
    chk("wide.f3_rise", rise_w, 32'h0);
    chk("wide.f3_fall", fall_w, 32'h25A5_0001);
    tick();
    chk("wide.f4_fall", fall_w, 32'h0);
    chk("wide.f4_io",   io_w,   32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_sw_debounce
`default_nettype wire
